// File: rtl/dp_pkg.sv
// Shared definitions for the multicycle datapath: operand-select and ALU
// encodings, instruction field positions and an instruction field decoder.
package dp_pkg;

   // ALU B operand sources
   typedef enum logic [1:0] {
      SRCB_B    = 2'b00,
      SRCB_ONE  = 2'b01,
      SRCB_IMM  = 2'b10,
      SRCB_ZERO = 2'b11
   } srcb_e;

   // ALU operations
   typedef enum logic {
      ALU_ADD = 1'b0,
      ALU_SUB = 1'b1
   } alu_op_e;

   // Instruction field bit positions (all fields live in the low 16 bits)
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS1_MSB = 8;
   localparam int RS1_LSB = 6;
   localparam int RS2_MSB = 5;
   localparam int RS2_LSB = 3;
   localparam int IMM_MSB = 5;
   localparam int IMM_LSB = 0;

   localparam int IMM_W  = IMM_MSB - IMM_LSB + 1;
   localparam int REG_AW = RD_MSB - RD_LSB + 1;

   // Decoded instruction fields
   typedef struct packed {
      logic [3:0]        op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [IMM_W-1:0]  imm;
   } ir_fields_t;

   // Split the instruction word into its fields
   function automatic ir_fields_t decode_ir(input logic [15:0] ir);
      ir_fields_t f;
      f.op  = ir[OP_MSB:OP_LSB];
      f.rd  = ir[RD_MSB:RD_LSB];
      f.rs1 = ir[RS1_MSB:RS1_LSB];
      f.rs2 = ir[RS2_MSB:RS2_LSB];
      f.imm = ir[IMM_MSB:IMM_LSB];
      return f;
   endfunction

endpackage

// File: rtl/dp_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// r0 hard-wired to zero, asynchronous active-low reset of every entry.
// Optional build macro RF_BYPASS_EN forwards same-edge write data onto the
// read ports so A/B capture the value being written.
module dp_regfile
   import dp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREGS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ra1,
   input  logic [REG_AW-1:0] ra2,
   output logic [WIDTH-1:0]  rd1,
   output logic [WIDTH-1:0]  rd2,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [WIDTH-1:0]  wd
);

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] raw1;
   logic [WIDTH-1:0] raw2;
   logic             wr_ok;

   // r0 and addresses beyond the configured depth are never written
   assign wr_ok = we && (wa != '0) && (int'(wa) < NREGS);

   // Register storage with write port
   // NOTE: the array is reset entry by entry because software relies on all
   // registers reading zero after reset; this rules out a RAM macro here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         // NOTE: state is updated with <= so every reader in this edge sees
         // the pre-edge value, independent of block evaluation order.
         regs[wa] <= wd;
      end
   end

   // Raw reads: r0 and out-of-range addresses return zero
   assign raw1 = (ra1 == '0 || int'(ra1) >= NREGS) ? '0 : regs[ra1];
   assign raw2 = (ra2 == '0 || int'(ra2) >= NREGS) ? '0 : regs[ra2];

`ifdef RF_BYPASS_EN
   // Forward write data to a read port that addresses the register being written
   always_comb begin
      // NOTE: defaults first so every path assigns rd1/rd2 and no latch forms.
      rd1 = raw1;
      rd2 = raw2;
      if (wr_ok) begin
         if (wa == ra1) rd1 = wd;
         if (wa == ra2) rd2 = wd;
      end
   end
`else
   assign rd1 = raw1;
   assign rd2 = raw2;
`endif

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath: PC, IR, MDR, A, B, ALUOut and the register file,
// driven by per-state strobes from the control FSM. Owns the unified memory
// port and returns the opcode nibble to the FSM.
// Optional build macro RF_BYPASS_EN (see dp_regfile) lets A/B capture
// write-back data on the same edge.
module mc_datapath
   import dp_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter int               NREGS    = 8,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             IR_EN,
   input  logic             IorD,
   input  logic             MemWrite,
   input  logic             RegWrite,
   input  logic             RegDataSel,
   input  logic             SRCA,
   input  logic [1:0]       SRCB,
   input  logic             ALUOp,
   input  logic             BranchOut,
   output logic [3:0]       op,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [WIDTH-1:0] pc_out
);

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] ir;
   logic [WIDTH-1:0] mdr;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] alu_out;

   ir_fields_t       fields;
   logic [WIDTH-1:0] imm_ext;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [WIDTH-1:0] alu;
   logic [WIDTH-1:0] wb_data;
   logic [WIDTH-1:0] rf_rd1;
   logic [WIDTH-1:0] rf_rd2;

   assign fields  = decode_ir(ir[15:0]);
   assign imm_ext = {{(WIDTH - IMM_W){fields.imm[IMM_W-1]}}, fields.imm};

   // ALU operand muxes and adder/subtractor (wraps modulo 2^WIDTH)
   assign src_a = SRCA ? a : pc;

   // B operand select
   always_comb begin
      src_b = b;
      case (srcb_e'(SRCB))
         SRCB_B:    src_b = b;
         SRCB_ONE:  src_b = WIDTH'(1);
         SRCB_IMM:  src_b = imm_ext;
         SRCB_ZERO: src_b = '0;
      endcase
   end

   assign alu = (alu_op_e'(ALUOp) == ALU_SUB) ? (src_a - src_b) : (src_a + src_b);

   // Write-back uses ALUOut/MDR as they stand before the edge
   assign wb_data = RegDataSel ? alu_out : mdr;

   dp_regfile #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_regfile (
      .clk   (CLK),
      .rst_n (reset),
      .ra1   (fields.rs1),
      .ra2   (fields.rs2),
      .rd1   (rf_rd1),
      .rd2   (rf_rd2),
      .we    (RegWrite),
      .wa    (fields.rd),
      .wd    (wb_data)
   );

   // Non-architectural registers refreshed every cycle; IR loads on IR_EN
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         ir      <= '0;
         mdr     <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
      end else begin
         a       <= rf_rd1;
         b       <= rf_rd2;
         mdr     <= mem_rdata;
         alu_out <= alu;
         if (IR_EN) ir <= mem_rdata;
      end
   end

   // PC: the branch strobe owns PC for its cycle (a failed compare holds even
   // if IR_EN is also set); otherwise a fetch writes the ALU result
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else if (BranchOut) begin
         if (a == b) pc <= alu_out;
      end else if (IR_EN) begin
         pc <= alu;
      end
   end

   assign op        = fields.op;
   assign mem_addr  = IorD ? alu_out : pc;
   assign mem_wdata = b;
   assign mem_we    = MemWrite;
   assign pc_out    = pc;

endmodule

// File: tb/tb_mc_datapath.sv
// Testbench for mc_datapath: directed scenarios followed by random control
// strobes, all checked cycle by cycle against an instruction-level model of
// the datapath state plus a private copy of memory.
module tb_mc_datapath;

   localparam logic [15:0] RST_PC = 16'h0010;

   typedef struct packed {
      logic       ir_en;
      logic       iord;
      logic       memwrite;
      logic       regwrite;
      logic       regdatasel;
      logic       srca;
      logic [1:0] srcb;
      logic       aluop;
      logic       branch;
   } ctl_t;

   localparam ctl_t IDLE = '0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ir_en = 1'b0, iord = 1'b0, memwrite = 1'b0, regwrite = 1'b0;
   logic        regdatasel = 1'b0, srca = 1'b0, aluop = 1'b0, branch = 1'b0;
   logic [1:0]  srcb = 2'b00;
   logic [3:0]  op;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_out;
   logic        mem_we;

   // Environment memory driven by the DUT, and the model's private copy
   logic [15:0] mem     [65536];
   logic [15:0] ref_mem [65536];

   // Model state
   logic [15:0] m_pc, m_ir, m_mdr, m_a, m_b, m_alu_out;
   logic [15:0] m_rf [8];

   int n_checks = 0;
   int n_fail   = 0;

   mc_datapath #(
      .WIDTH    (16),
      .NREGS    (8),
      .RESET_PC (RST_PC)
   ) dut (
      .CLK        (clk),
      .reset      (rst_n),
      .IR_EN      (ir_en),
      .IorD       (iord),
      .MemWrite   (memwrite),
      .RegWrite   (regwrite),
      .RegDataSel (regdatasel),
      .SRCA       (srca),
      .SRCB       (srcb),
      .ALUOp      (aluop),
      .BranchOut  (branch),
      .op         (op),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .pc_out     (pc_out)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we && rst_n) mem[mem_addr] <= mem_wdata;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running want done");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h want 0x%0h", tag, $time, got, exp);
      end
   endtask

   function automatic ctl_t mk(input bit ie, input bit io, input bit mw, input bit rw,
                               input bit rds, input bit sa, input logic [1:0] sb,
                               input bit ao, input bit br);
      ctl_t c;
      c.ir_en = ie; c.iord = io; c.memwrite = mw; c.regwrite = rw;
      c.regdatasel = rds; c.srca = sa; c.srcb = sb; c.aluop = ao; c.branch = br;
      return c;
   endfunction

   function automatic logic [15:0] ins(input logic [2:0] rd, input logic [2:0] rs1,
                                       input logic [2:0] rs2, input logic [2:0] low);
      return {4'h0, rd, rs1, rs2, low};
   endfunction

   task automatic drive(input ctl_t c);
      ir_en = c.ir_en; iord = c.iord; memwrite = c.memwrite; regwrite = c.regwrite;
      regdatasel = c.regdatasel; srca = c.srca; srcb = c.srcb; aluop = c.aluop;
      branch = c.branch;
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_alu_out = '0;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
   endtask

   task automatic compare_outputs(input ctl_t c);
      check("op",        {28'd0, op},   {28'd0, m_ir[15:12]});
      check("mem_addr",  {16'd0, mem_addr},  {16'd0, (c.iord ? m_alu_out : m_pc)});
      check("mem_wdata", {16'd0, mem_wdata}, {16'd0, m_b});
      check("mem_we",    {31'd0, mem_we},    {31'd0, c.memwrite});
      check("pc_out",    {16'd0, pc_out},    {16'd0, m_pc});
   endtask

   task automatic poke(input logic [15:0] addr, input logic [15:0] val);
      mem[addr] = val;
      ref_mem[addr] = val;
   endtask

   // One clock cycle: drive strobes, advance the model, compare outputs
   task automatic step(input ctl_t c);
      logic [15:0] addr, rdata, sa, sb, imm, alu, wb, n_a, n_b, n_pc;
      logic [2:0]  rd, rs1, rs2;
      @(negedge clk);
      drive(c);
      rd  = m_ir[11:9];
      rs1 = m_ir[8:6];
      rs2 = m_ir[5:3];
      imm = {{10{m_ir[5]}}, m_ir[5:0]};
      addr  = c.iord ? m_alu_out : m_pc;
      rdata = ref_mem[addr];
      sa = c.srca ? m_a : m_pc;
      case (c.srcb)
         2'b00:   sb = m_b;
         2'b01:   sb = 16'd1;
         2'b10:   sb = imm;
         default: sb = 16'd0;
      endcase
      alu = c.aluop ? sa - sb : sa + sb;
      wb  = c.regdatasel ? m_alu_out : m_mdr;
      n_a = m_rf[rs1];
      n_b = m_rf[rs2];
`ifdef RF_BYPASS_EN
      if (c.regwrite && rd != 3'd0) begin
         if (rd == rs1) n_a = wb;
         if (rd == rs2) n_b = wb;
      end
`endif
      n_pc = m_pc;
      if (c.branch) begin
         if (m_a == m_b) n_pc = m_alu_out;
      end else if (c.ir_en) begin
         n_pc = alu;
      end
      @(posedge clk);
      if (c.memwrite) ref_mem[addr] = m_b;
      if (c.regwrite && rd != 3'd0) m_rf[rd] = wb;
      if (c.ir_en) m_ir = rdata;
      m_mdr = rdata; m_a = n_a; m_b = n_b; m_alu_out = alu; m_pc = n_pc;
      #1;
      compare_outputs(c);
   endtask

   task automatic fetch(input logic [15:0] instr);
      poke(m_pc, instr);
      step(mk(1, 0, 0, 0, 0, 0, 2'b01, 0, 0));
   endtask

   // rd <= sign-extended imm6 via r0 + imm
   task automatic li(input logic [2:0] rd, input logic [5:0] imm6);
      fetch({4'h0, rd, 3'd0, imm6});
      step(IDLE);
      step(mk(0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
      step(mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 0));
   endtask

   task automatic alu_rr(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                         input bit sub);
      fetch(ins(rd, rs1, rs2, 3'd0));
      step(IDLE);
      step(mk(0, 0, 0, 0, 0, 1, 2'b00, sub, 0));
      step(mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 0));
   endtask

   // rd <= mem[r7]
   task automatic load_word(input logic [2:0] rd);
      fetch(ins(rd, 3'd7, 3'd0, 3'd0));
      step(IDLE);
      step(mk(0, 0, 0, 0, 0, 1, 2'b11, 0, 0));
      step(mk(0, 1, 0, 0, 0, 1, 2'b11, 0, 0));
      step(mk(0, 0, 0, 1, 0, 1, 2'b11, 0, 0));
   endtask

   // Expose a register on mem_wdata (B) and compare with a fixed value
   task automatic peek(input logic [2:0] r, input logic [15:0] exp, input string tag);
      fetch(ins(3'd0, 3'd0, r, 3'd0));
      step(IDLE);
      check(tag, {16'd0, mem_wdata}, {16'd0, exp});
   endtask

   // Branch instr: rs1=1, rs2=3, imm6 = 6'b011001 = 25; target = r1 + 25
   task automatic branch_setup();
      fetch(ins(3'd0, 3'd1, 3'd3, 3'd1));
      step(IDLE);
      step(mk(0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
   endtask

   initial begin
      logic [15:0] hold_pc;
      logic [15:0] exp_a;
      logic [9:0]  rnd;
      ctl_t        c;

      for (int i = 0; i < 65536; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      model_reset();
      drive(IDLE);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_op",        {28'd0, op},        32'h0);
      check("rst_mem_addr",  {16'd0, mem_addr},  32'h0010);
      check("rst_mem_wdata", {16'd0, mem_wdata}, 32'h0);
      check("rst_pc_out",    {16'd0, pc_out},    32'h0010);

      // Fetch from the reset PC
      poke(16'h0010, 16'h1240);
      step(mk(1, 0, 0, 0, 0, 0, 2'b01, 0, 0));
      check("fetch_pc", {16'd0, pc_out}, 32'h0011);
      check("fetch_op", {28'd0, op},     32'h1);

      // Subtract, both signs
      li(3'd1, 6'd5);
      li(3'd2, 6'd3);
      alu_rr(3'd3, 3'd1, 3'd2, 1'b1);
      peek(3'd3, 16'h0002, "sub_pos");
      li(3'd1, 6'd3);
      li(3'd2, 6'd5);
      alu_rr(3'd3, 3'd1, 3'd2, 1'b1);
      peek(3'd3, 16'hFFFE, "sub_wrap");

      // Build r7 = 0x40, then load and store through ALUOut addressing
      li(3'd1, 6'd16);
      alu_rr(3'd7, 3'd1, 3'd1, 1'b0);
      alu_rr(3'd7, 3'd7, 3'd7, 1'b0);
      poke(16'h0040, 16'h1234);
      load_word(3'd6);
      poke(16'h0040, 16'hBEEF);
      load_word(3'd4);
      peek(3'd4, 16'hBEEF, "load_r4");
      fetch(ins(3'd0, 3'd7, 3'd6, 3'd0));
      step(IDLE);
      step(mk(0, 0, 0, 0, 0, 1, 2'b11, 0, 0));
      step(mk(0, 1, 1, 0, 0, 1, 2'b11, 0, 0));
      check("st_we",    {31'd0, mem_we},    32'h1);
      check("st_addr",  {16'd0, mem_addr},  32'h0040);
      check("st_wdata", {16'd0, mem_wdata}, 32'h1234);
      check("st_mem",   {16'd0, mem[16'h0040]}, 32'h1234);

      // Branches: taken, not taken, taken with IR_EN also set
      li(3'd1, 6'd7);
      li(3'd3, 6'd7);
      branch_setup();
      step(mk(0, 0, 0, 0, 0, 1, 2'b10, 0, 1));
      check("br_taken", {16'd0, pc_out}, 32'h0020);
      li(3'd3, 6'd8);
      branch_setup();
      hold_pc = m_pc;
      step(mk(0, 0, 0, 0, 0, 1, 2'b10, 0, 1));
      check("br_not_taken", {16'd0, pc_out}, {16'd0, hold_pc});
      li(3'd3, 6'd7);
      branch_setup();
      poke(m_pc, 16'h0000);
      step(mk(1, 0, 0, 0, 0, 1, 2'b10, 0, 1));
      check("br_with_fetch", {16'd0, pc_out}, 32'h0020);

      // r0 ignores writes of 0xFFFF
      fetch(ins(3'd0, 3'd0, 3'd7, 3'd7));
      step(IDLE);
      step(mk(0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
      step(mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 0));
      peek(3'd0, 16'h0000, "r0_zero");

      // Same-edge write/read of r5 (old value 3, new value 0xAA from MDR)
      li(3'd5, 6'd3);
      fetch(ins(3'd5, 3'd5, 3'd0, 3'd0));
      poke(m_pc, 16'h00AA);
      step(IDLE);
      step(mk(0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
      step(mk(0, 1, 0, 0, 0, 1, 2'b11, 0, 0));
`ifdef RF_BYPASS_EN
      exp_a = 16'h00AA;
`else
      exp_a = 16'h0003;
`endif
      check("same_edge_a", {16'd0, mem_addr}, {16'd0, exp_a});

      // Reset asserted mid-instruction with write strobes active
      fetch(ins(3'd2, 3'd1, 3'd3, 3'd0));
      step(IDLE);
      c = mk(0, 0, 1, 1, 1, 0, 2'b00, 0, 0);
      @(negedge clk);
      drive(c);
      #2 rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      compare_outputs(c);
      @(negedge clk);
      drive(IDLE);
      rst_n = 1'b1;
      #1;
      check("mid_rst_pc",    {16'd0, pc_out},    32'h0010);
      check("mid_rst_addr",  {16'd0, mem_addr},  32'h0010);
      check("mid_rst_op",    {28'd0, op},        32'h0);
      check("mid_rst_wdata", {16'd0, mem_wdata}, 32'h0);
      for (int r = 1; r < 8; r++) begin
         peek(3'(r), 16'h0000, $sformatf("rst_r%0d", r));
      end

      // Random strobes; branch and fetch are not combined here
      for (int n = 0; n < 500; n++) begin
         rnd = 10'($urandom);
         c = rnd;
         if (c.branch) c.ir_en = 1'b0;
         step(c);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
